instr_fetch_ctrl: RTL and testbench



---
 rtl/instr_fetch_ctrl_if.sv | 26 ++
 rtl/instr_fetch_ctrl.sv | 102 ++++++++++
 tb/tb_instr_fetch_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-side bus: ROM read port, decode-facing valid/ready output, redirect and halt.
interface instr_fetch_ctrl_if #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 20
) ();
  logic              fetch_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt;

  modport master (
    input  fetch_en, rom_data, instr_ready, redirect_valid, redirect_pc,
    output rom_addr, instr, instr_pc, instr_valid, halt
  );

  modport slave (
    output fetch_en, rom_data, instr_ready, redirect_valid, redirect_pc,
    input  rom_addr, instr, instr_pc, instr_valid, halt
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, reads the ROM combinationally and
// buffers one instruction word toward decode over a valid/ready handshake.
module instr_fetch_ctrl #(
  parameter int unsigned ADDR_W    = 20,
  parameter int unsigned DATA_W    = 20,
  parameter int unsigned ROM_DEPTH = 20,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_ctrl_if.master  bus
);

  typedef enum logic [1:0] {StIdle, StFetch, StHalt} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              valid_q, valid_d;
  logic              halt_q, halt_d;

  logic in_range;
  logic handshake;
  logic out_free;

  assign in_range  = 32'(pc_q) < ROM_DEPTH;
  assign handshake = valid_q & bus.instr_ready;
  assign out_free  = ~valid_q | bus.instr_ready;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    halt_d     = halt_q;

    if (handshake) begin
      valid_d = 1'b0;
    end

    if (bus.redirect_valid) begin
      // Redirect flushes the buffer; a same-cycle handshake has already been taken.
      pc_d    = bus.redirect_pc;
      valid_d = 1'b0;
      halt_d  = 1'b0;
      state_d = StFetch;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.fetch_en) begin
            state_d = StFetch;
          end
        end
        StFetch: begin
          if (!in_range) begin
            state_d = StHalt;
            halt_d  = 1'b1;
          end else if (!bus.fetch_en) begin
            state_d = StIdle;
          end else if (out_free) begin
            instr_d    = bus.rom_data;
            instr_pc_d = pc_q;
            valid_d    = 1'b1;
            pc_d       = pc_q + 1'b1;
          end
        end
        StHalt: begin
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= ADDR_W'(RESET_PC);
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      halt_q     <= halt_d;
    end
  end

  assign bus.rom_addr    = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.halt        = halt_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: ROM model plus a queue of expected
// fetch addresses popped on every decode handshake.
module tb_instr_fetch_ctrl;

  localparam int unsigned ADDR_W    = 20;
  localparam int unsigned DATA_W    = 20;
  localparam int unsigned ROM_DEPTH = 20;

  logic clk = 1'b0;
  logic rst;

  int tests = 0;
  int fails = 0;
  logic [ADDR_W-1:0] sb[$];

  always #5 clk = ~clk;

  instr_fetch_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifc ();

  instr_fetch_ctrl #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .ROM_DEPTH(ROM_DEPTH),
    .RESET_PC (0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    return (a * 20'd1237) ^ 20'hA5000;
  endfunction

  assign ifc.rom_data = rom_word(ifc.rom_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Score any handshake that the coming edge will perform, then advance one cycle.
  task automatic tick();
    logic [ADDR_W-1:0] e;
    if (ifc.instr_valid === 1'b1 && ifc.instr_ready === 1'b1) begin
      tests++;
      assert (sb.size() > 0)
      else begin
        fails++;
        $error("FAIL sb_unexpected: observed pc %0h, expected no word", ifc.instr_pc);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_pc", ifc.instr_pc, e);
        chk("sb_data", ifc.instr, rom_word(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) sb.push_back(ADDR_W'(i));
  endtask

  initial begin
    rst                = 1'b1;
    ifc.fetch_en       = 1'b0;
    ifc.instr_ready    = 1'b0;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc    = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", ifc.instr_valid, 0);
    chk("rst_halt", ifc.halt, 0);
    chk("rst_addr", ifc.rom_addr, 0);
    chk("rst_instr", ifc.instr, 0);
    chk("rst_instr_pc", ifc.instr_pc, 0);

    // Full sweep: 20 words back to back, then halt.
    ifc.fetch_en    = 1'b1;
    ifc.instr_ready = 1'b1;
    push_range(0, 19);
    for (int i = 0; i < 21; i++) tick();
    chk("sweep_one_left", sb.size(), 1);
    tick();
    chk("sweep_drained", sb.size(), 0);
    chk("sweep_halt", ifc.halt, 1);
    chk("sweep_valid", ifc.instr_valid, 0);
    chk("sweep_addr", ifc.rom_addr, 20);
    for (int i = 0; i < 3; i++) tick();
    chk("halt_hold_addr", ifc.rom_addr, 20);
    chk("halt_hold", ifc.halt, 1);
    chk("halt_hold_valid", ifc.instr_valid, 0);

    // From HALT, redirect to 0.
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 20'd0;
    tick();
    ifc.redirect_valid = 1'b0;
    chk("unhalt_halt", ifc.halt, 0);
    chk("unhalt_valid", ifc.instr_valid, 0);
    tick();
    chk("unhalt_first_valid", ifc.instr_valid, 1);
    chk("unhalt_first_pc", ifc.instr_pc, 0);

    // Backpressure while word 5 is presented.
    push_range(0, 4);
    for (int i = 0; i < 5; i++) tick();
    ifc.instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_pc", ifc.instr_pc, 5);
      chk("stall_instr", ifc.instr, rom_word(20'd5));
      chk("stall_valid", ifc.instr_valid, 1);
      chk("stall_addr", ifc.rom_addr, 6);
      tick();
    end
    chk("stall_end_pc", ifc.instr_pc, 5);
    ifc.instr_ready = 1'b1;
    push_range(5, 6);
    tick();
    tick();
    chk("release_drained", sb.size(), 0);
    chk("release_next_pc", ifc.instr_pc, 7);

    // Redirect to 2 while word 7 is held (not consumed: flushed).
    ifc.instr_ready    = 1'b0;
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 20'd2;
    tick();
    ifc.redirect_valid = 1'b0;
    chk("redir_bubble", ifc.instr_valid, 0);
    chk("redir_addr", ifc.rom_addr, 2);
    ifc.instr_ready = 1'b1;
    push_range(2, 4);
    tick();
    chk("redir_first_valid", ifc.instr_valid, 1);
    chk("redir_first_pc", ifc.instr_pc, 2);
    tick();
    chk("redir_second_pc", ifc.instr_pc, 3);
    tick();
    chk("redir_third_pc", ifc.instr_pc, 4);

    // Out-of-range redirect; word 4 handshakes on the redirect edge.
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 20'd25;
    tick();
    ifc.redirect_valid = 1'b0;
    chk("oor_consumed", sb.size(), 0);
    chk("oor_valid0", ifc.instr_valid, 0);
    chk("oor_halt0", ifc.halt, 0);
    tick();
    chk("oor_halt1", ifc.halt, 1);
    chk("oor_valid1", ifc.instr_valid, 0);
    tick();
    chk("oor_valid2", ifc.instr_valid, 0);
    chk("oor_addr", ifc.rom_addr, 25);

    // fetch_en drop with a buffered word.
    ifc.instr_ready    = 1'b0;
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 20'd10;
    tick();
    ifc.redirect_valid = 1'b0;
    tick();
    chk("fe_buf_pc", ifc.instr_pc, 10);
    ifc.fetch_en = 1'b0;
    tick();
    chk("fe_hold_valid", ifc.instr_valid, 1);
    chk("fe_hold_pc", ifc.instr_pc, 10);
    push_range(10, 10);
    ifc.instr_ready = 1'b1;
    tick();
    chk("fe_drained", sb.size(), 0);
    chk("fe_valid", ifc.instr_valid, 0);
    for (int i = 0; i < 3; i++) tick();
    chk("fe_idle_valid", ifc.instr_valid, 0);
    chk("fe_idle_addr", ifc.rom_addr, 11);

    // Mid-stream reset drops the buffered word.
    ifc.fetch_en = 1'b1;
    tick();
    tick();
    chk("rst2_pre_valid", ifc.instr_valid, 1);
    chk("rst2_pre_pc", ifc.instr_pc, 11);
    ifc.instr_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ifc.fetch_en = 1'b0;
    chk("rst2_valid", ifc.instr_valid, 0);
    chk("rst2_addr", ifc.rom_addr, 0);
    chk("rst2_halt", ifc.halt, 0);
    chk("rst2_instr", ifc.instr, 0);
    chk("rst2_instr_pc", ifc.instr_pc, 0);
    tick();
    chk("rst2_idle_valid", ifc.instr_valid, 0);
    chk("final_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
